mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 mux datapath between four requesters. It drives the mux `sel` input and a one-hot grant back to the requesters. Once a requester wins, it keeps its grant while its request stays high, up to a bounded burst, and the mux select always matches the current owner. It sits directly in front of the 4:1 mux, replacing the free-running select counter used in simulation benches.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/rr_pick4.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 95 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4:1 mux round-robin arbiter.
package mux_arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set bit of (req & ~mask), scanning from ptr upward mod 4.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               found
);

   logic [NUM_REQ-1:0] eff;
   logic [SEL_W-1:0]   cand;

   always_comb begin
      eff   = req & ~mask;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!found && eff[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select with bounded-burst ownership.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid
);

   localparam int unsigned CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

   arb_state_t         state, state_n;
   logic [SEL_W-1:0]   own, own_n;
   logic [SEL_W-1:0]   ptr, ptr_n;
   logic [CW-1:0]      cnt, cnt_n;

   logic [NUM_REQ-1:0] pick_mask;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_found;

   // One picker serves both cases: in BUSY the owner is masked, so "found" means others != 0.
   assign pick_mask = (state == BUSY) ? onehot4(own) : '0;

   rr_pick4 u_pick (
      .req   (req),
      .mask  (pick_mask),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_n = state;
      own_n   = own;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = BUSY;
               own_n   = pick_idx;
               cnt_n   = CW'(1);
               ptr_n   = pick_idx + SEL_W'(1);
            end
         end
         BUSY: begin
            if (!req[own]) begin
               if (pick_found) begin
                  own_n = pick_idx;
                  cnt_n = CW'(1);
                  ptr_n = pick_idx + SEL_W'(1);
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end else if (cnt >= MAX_C && pick_found) begin
               own_n = pick_idx;
               cnt_n = CW'(1);
               ptr_n = pick_idx + SEL_W'(1);
            end else if (cnt < MAX_C) begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         own   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         own   <= own_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   assign gnt       = (state == BUSY) ? onehot4(own) : '0;
   assign sel       = own;
   assign sel_valid = (state == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD=8 and MAX_HOLD=1 instances).
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt,  gnt1;
   logic [1:0] sel,  sel1;
   logic       sel_valid, sel_valid1;

   int n_chk;
   int n_err;

   mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .sel_valid (sel_valid)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt1),
      .sel       (sel1),
      .sel_valid (sel_valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b0;
      req   = 4'b1111;

      // Reset held for 3 edges under full request
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_gnt",  int'(gnt), 0);
         chk("rst_sel",  int'(sel), 0);
         chk("rst_sv",   int'(sel_valid), 0);
         chk("rst_gnt1", int'(gnt1), 0);
      end

      // Single requester, then release
      reset = 1'b1;
      req   = 4'b0100;
      step();
      chk("single_gnt", int'(gnt), 4'b0100);
      chk("single_sel", int'(sel), 2);
      chk("single_sv",  int'(sel_valid), 1);
      req = 4'b0000;
      step();
      chk("rel_gnt", int'(gnt), 0);
      chk("rel_sel", int'(sel), 2);
      chk("rel_sv",  int'(sel_valid), 0);

      // Full contention: 8-cycle bursts on dut, per-cycle rotation on dut1
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         step();
         chk("cont_gnt",  int'(gnt),  1 << ((c / 8) % 4));
         chk("cont_sel",  int'(sel),  (c / 8) % 4);
         chk("cont_sv",   int'(sel_valid), 1);
         chk("rot_gnt1",  int'(gnt1), 1 << (c % 4));
         chk("rot_sel1",  int'(sel1), c % 4);
      end

      // Release hand-off with no idle gap
      do_reset();
      req = 4'b0011;
      step();
      chk("ho_own0_a", int'(gnt), 4'b0001);
      step();
      chk("ho_own0_b", int'(gnt), 4'b0001);
      req = 4'b0010;
      step();
      chk("ho_gnt", int'(gnt), 4'b0010);
      chk("ho_sel", int'(sel), 1);
      chk("ho_sv",  int'(sel_valid), 1);

      // Uncontended hold: counter saturates at MAX_HOLD
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("hold_gnt", int'(gnt), 4'b0001);
      end
      chk("hold_cnt", int'(dut.cnt), 8);

      // Reset mid-burst, then arbitration restarts from ptr=0
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 5; c++) step();
      chk("mid_gnt", int'(gnt), 4'b0100);
      chk("mid_cnt", int'(dut.cnt), 5);
      reset = 1'b0;
      step();
      chk("mid_rst_gnt", int'(gnt), 0);
      chk("mid_rst_sel", int'(sel), 0);
      chk("mid_rst_sv",  int'(sel_valid), 0);
      reset = 1'b1;
      req   = 4'b1001;
      step();
      chk("post_gnt", int'(gnt), 4'b0001);
      chk("post_sel", int'(sel), 0);

      // Early drop: grant issued once, released next edge
      do_reset();
      req = 4'b1000;
      step();
      req = 4'b0000;
      chk("drop_gnt", int'(gnt), 4'b1000);
      step();
      chk("drop_rel", int'(gnt), 0);
      chk("drop_sel", int'(sel), 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
